// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operations, opcodes, PC-source and destination-select codes.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0a,
    OP_SLTIU = 6'h0b,
    OP_ANDI  = 6'h0c,
    OP_ORI   = 6'h0d,
    OP_XORI  = 6'h0e,
    OP_LUI   = 6'h0f,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b,
    OP_HALT  = 6'h3f
  } opcode_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [1:0] RDSEL_RD = 2'd0;
  localparam logic [1:0] RDSEL_RT = 2'd1;
  localparam logic [1:0] RDSEL_RA = 2'd2;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU; shifts move portB by the amount in portA[4:0].
module ex_alu
  import cpu_types_pkg::*;
(
  input  word_t  portA,
  input  word_t  portB,
  input  aluop_t aluOp,
  output word_t  out,
  output logic   zero,
  output logic   neg,
  output logic   ovf
);

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (aluOp)
      ALU_SLL:  out = portB << portA[4:0];
      ALU_SRL:  out = portB >> portA[4:0];
      ALU_SRA:  out = word_t'($signed(portB) >>> portA[4:0]);
      ALU_ADD: begin
        out = portA + portB;
        ovf = (portA[31] == portB[31]) && (out[31] != portA[31]);
      end
      ALU_SUB: begin
        out = portA - portB;
        ovf = (portA[31] != portB[31]) && (out[31] != portA[31]);
      end
      ALU_AND:  out = portA & portB;
      ALU_OR:   out = portA | portB;
      ALU_XOR:  out = portA ^ portB;
      ALU_NOR:  out = ~(portA | portB);
      ALU_SLT:  out = {31'b0, $signed(portA) < $signed(portB)};
      ALU_SLTU: out = {31'b0, portA < portB};
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);
  assign neg  = out[31];

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM latch, branch/jump redirect and sticky halt.
// Define EX_FWD_EN to forward MEM/WB results into the ALU operands.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] curr_pc_i,
  input  logic [WORD_W-1:0] rdat1_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic              regWr_i,
  input  logic              dWEN_i,
  input  logic              dREN_i,
  input  logic              shift_i,
  input  logic              jpSel_i,
  input  logic              aluSrc_i,
  input  logic              halt_i,
  input  aluop_t            aluOp_i,
  input  logic [2:0]        rdSel_i,
  input  logic [1:0]        pcSrc_i,
  input  logic              wb_regWr_i,
  input  logic [REG_W-1:0]  wb_wsel_i,
  input  logic [WORD_W-1:0] wb_wdat_i,
  output logic              redirect_o,
  output logic [WORD_W-1:0] redirect_pc_o,
  output logic [WORD_W-1:0] result_o,
  output logic [WORD_W-1:0] store_o,
  output logic [WORD_W-1:0] npc_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [REG_W-1:0]  wsel_o,
  output logic              regWr_o,
  output logic              dWEN_o,
  output logic              dREN_o,
  output logic              halt_o,
  output logic              jpSel_o,
  output logic              wbSrc_o
);

  opcode_t    opcode;
  regbits_t   rs, rt, wsel;
  word_t      imm_sext, imm_zext, fwd_a, fwd_b, op_a, op_b, alu_out, target;
  logic       alu_zero, taken, unused_neg, unused_ovf;

  assign opcode   = opcode_t'(instr_i[31:26]);
  assign rs       = instr_i[25:21];
  assign rt       = instr_i[20:16];
  assign imm_sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext = {16'b0, instr_i[15:0]};

`ifdef EX_FWD_EN
  logic mem_fwd_ok, wb_fwd_ok;
  // Loads are excluded from MEM forwarding: their data is not yet available.
  assign mem_fwd_ok = regWr_o && !dREN_o && (wsel_o != '0);
  assign wb_fwd_ok  = wb_regWr_i && (wb_wsel_i != '0);

  always_comb begin
    fwd_a = rdat1_i;
    fwd_b = rdat2_i;
    if (mem_fwd_ok && wsel_o == rs)         fwd_a = result_o;
    else if (wb_fwd_ok && wb_wsel_i == rs)  fwd_a = wb_wdat_i;
    if (mem_fwd_ok && wsel_o == rt)         fwd_b = result_o;
    else if (wb_fwd_ok && wb_wsel_i == rt)  fwd_b = wb_wdat_i;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regWr_i, wb_wsel_i, wb_wdat_i};
  assign fwd_a     = rdat1_i;
  assign fwd_b     = rdat2_i;
`endif

  logic unused_pc;
  assign unused_pc = ^curr_pc_i;

  assign op_a = shift_i ? {27'b0, instr_i[10:6]} : fwd_a;

  always_comb begin
    op_b = fwd_b;
    if (aluSrc_i) begin
      case (opcode)
        OP_LUI:                  op_b = {instr_i[15:0], 16'b0};
        OP_ANDI, OP_ORI, OP_XORI: op_b = imm_zext;
        default:                 op_b = imm_sext;
      endcase
    end
  end

  ex_alu u_alu (
    .portA (op_a),
    .portB (op_b),
    .aluOp (aluOp_i),
    .out   (alu_out),
    .zero  (alu_zero),
    .neg   (unused_neg),
    .ovf   (unused_ovf)
  );

  always_comb begin
    case (rdSel_i[1:0])
      RDSEL_RD: wsel = instr_i[15:11];
      RDSEL_RT: wsel = rt;
      RDSEL_RA: wsel = 5'd31;
      default:  wsel = '0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (pcSrc_i)
      PCSRC_BR: begin
        taken  = (opcode == OP_BEQ && alu_zero) || (opcode == OP_BNE && !alu_zero);
        target = npc_i + {imm_sext[29:0], 2'b00};
      end
      PCSRC_J: begin
        taken  = 1'b1;
        target = {npc_i[31:28], instr_i[25:0], 2'b00};
      end
      PCSRC_JR: begin
        taken  = 1'b1;
        target = fwd_a;
      end
      default: ;
    endcase
  end

  assign redirect_o    = nRST && en && !flush && !halt_o && taken;
  assign redirect_pc_o = redirect_o ? target : '0;

  // A bubble clears every field but cannot release a halted pipeline.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      result_o <= '0; store_o <= '0; npc_o <= '0; instr_o <= '0; wsel_o <= '0;
      regWr_o  <= 1'b0; dWEN_o <= 1'b0; dREN_o <= 1'b0; halt_o <= 1'b0;
      jpSel_o  <= 1'b0; wbSrc_o <= 1'b0;
    end else if (flush) begin
      result_o <= '0; store_o <= '0; npc_o <= '0; instr_o <= '0; wsel_o <= '0;
      regWr_o  <= 1'b0; dWEN_o <= 1'b0; dREN_o <= 1'b0;
      jpSel_o  <= 1'b0; wbSrc_o <= 1'b0;
    end else if (en && !halt_o) begin
      result_o <= jpSel_i ? npc_i : alu_out;
      store_o  <= fwd_b;
      npc_o    <= npc_i;
      instr_o  <= instr_i;
      wsel_o   <= wsel;
      regWr_o  <= regWr_i;
      dWEN_o   <= dWEN_i;
      dREN_o   <= dREN_i;
      halt_o   <= halt_i;
      jpSel_o  <= jpSel_i;
      wbSrc_o  <= rdSel_i[2];
    end
  end

endmodule
